// File: rtl/md_ctrl.sv
// md_ctrl -- HI/LO multiply/divide controller for a MIPS-style pipeline.
//
// A multi-cycle unit that owns the architectural HI and LO registers.
// mult/multu/div/divu capture their operands when they are launched, hold
// busy high for a fixed number of cycles and write HI/LO on the edge that
// ends the last busy cycle. mthi/mtlo write HI or LO directly, with no busy
// cycle.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous active-low reset
//   start  in   one-cycle launch strobe from the E stage
//   op     in   [2:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//               6 mtlo, 7 reserved (treated as none)
//   A      in   [31:0] rs operand / dividend / mthi-mtlo source
//   B      in   [31:0] rt operand / divisor
//   busy   out  operation in progress
//   HI     out  [31:0] architectural HI register
//   LO     out  [31:0] architectural LO register
//
// Configuration macro:
//   MD_DIV0_KEEP_EN  defined: a divide by zero still runs DIV_CYCLES busy
//                    cycles but leaves HI/LO unchanged.
//                    undefined (default): a divide by zero writes HI = A
//                    and LO = 0xFFFFFFFF.

module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             capture;
  logic [31:0]      hi_next;
  logic [31:0]      lo_next;

  // Operands latched at launch; A/B may change freely during RUN.
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;

  // Datapath results, computed from the captured operands only.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        res_wr;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Sign-extend to 64 bits so the low 64 bits of the product are the
  // two's-complement signed product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes: the quotient truncates toward zero and the
  // remainder follows the dividend's sign. 0x80000000 / -1 falls out
  // naturally as 0x80000000 remainder 0 with no special case.
  assign a_neg  = (op_q == OP_DIV) & a_q[31];
  assign b_neg  = (op_q == OP_DIV) & b_q[31];
  assign a_mag  = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag  = b_neg ? (32'd0 - b_q) : b_q;
  // Divide-by-zero is handled separately; keep the divider operand nonzero.
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign quo_u  = a_mag / b_safe;
  assign rem_u  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
  assign rem    = a_neg ? (32'd0 - rem_u) : rem_u;

  assign busy = (state == RUN);

  // Select the HI/LO values to commit when the running operation finishes.
  always_comb begin
    res_wr = 1'b1;
    res_hi = HI;
    res_lo = LO;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
          res_wr = 1'b0;
`else
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
`endif
        end else begin
          res_hi = rem;
          res_lo = quo;
        end
      end
      default: begin
        res_wr = 1'b0;
      end
    endcase
  end

  // Next-state, counter and HI/LO update logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    hi_next    = HI;
    lo_next    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              capture    = 1'b1;
              cnt_next   = CNT_W'(MULT_CYCLES);
              state_next = RUN;
            end
            OP_DIV, OP_DIVU: begin
              capture    = 1'b1;
              cnt_next   = CNT_W'(DIV_CYCLES);
              state_next = RUN;
            end
            OP_MTHI: begin
              hi_next = A;
            end
            OP_MTLO: begin
              lo_next = A;
            end
            default: begin
              state_next = IDLE;
            end
          endcase
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        // cnt == 1 marks the last busy cycle; start is ignored throughout.
        if (cnt <= CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = {CNT_W{1'b0}};
          if (res_wr) begin
            hi_next = res_hi;
            lo_next = res_lo;
          end else begin
            hi_next = HI;
            lo_next = LO;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, captured operands and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= {CNT_W{1'b0}};
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 3'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      HI    <= hi_next;
      LO    <= lo_next;
      if (capture) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
    end
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning the number of busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles for div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle launch strobe, driven from the E stage.
REQ-006 The block SHALL have port op, input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 The block SHALL have port A, input, 32 bits: rs operand, dividend, or mthi/mtlo source.
REQ-008 The block SHALL have port B, input, 32 bits: rt operand or divisor.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress; consumed by the stall unit together with start.
REQ-010 The block SHALL have port HI, output, 32 bits: the architectural HI register.
REQ-011 The block SHALL have port LO, output, 32 bits: the architectural LO register.

Function
REQ-012 The block SHALL implement two states: IDLE (busy=0) and RUN (busy=1), plus a down-counter cnt wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, start=1 with op in 1..4 SHALL capture A, B and op on that edge, load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN; busy SHALL be 1 from the next cycle.
REQ-014 In RUN, cnt SHALL decrement each cycle; busy SHALL stay high for exactly N cycles, where N is the loaded count.
REQ-015 On the edge that ends the Nth busy cycle, HI/LO SHALL be written and the state SHALL return to IDLE, so the new HI/LO and busy=0 appear together.
REQ-016 mult SHALL produce the signed 64-bit product of the captured operands; multu SHALL produce the unsigned 64-bit product; in both cases HI=product[63:32] and LO=product[31:0].
REQ-017 div/divu SHALL write LO=quotient and HI=remainder; the signed quotient SHALL truncate toward zero and the signed remainder SHALL take the sign of the dividend.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 In IDLE, start=1 with op=5 (mthi) SHALL write HI=A, and with op=6 (mtlo) SHALL write LO=A, on the same edge, with no busy cycle.
REQ-020 start while in RUN SHALL be ignored: no operand capture and no HI/LO write.
REQ-021 start with op 0 or 7 SHALL have no effect.
REQ-022 HI/LO SHALL change only as specified in REQ-015 and REQ-019; mfhi/mflo are direct reads of the HI/LO outputs.
REQ-023 A captured operand SHALL NOT be affected by A/B changes during RUN.

Reset
REQ-024 While reset=0, asynchronously: state=IDLE, cnt=0, busy=0, HI=0, LO=0, and the captured operand registers SHALL be 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no HI/LO write; after release the block SHALL be IDLE.
REQ-026 The first start SHALL be accepted on the first rising edge with reset=1.

Configuration
REQ-027 Macro MD_DIV0_KEEP_EN defined: div/divu with captured B=0 SHALL still run DIV_CYCLES busy cycles but leave HI/LO unchanged.
REQ-028 Macro MD_DIV0_KEEP_EN undefined: div/divu with B=0 SHALL write HI=captured A and LO=0xFFFFFFFF after DIV_CYCLES.

Verification
REQ-029 mult: A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 multu: A=B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 div: A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; a second start during RUN is ignored.
REQ-032 mthi with A=0x12345678 in IDLE -> HI=0x12345678 the next cycle, busy stays 0, LO unchanged.
REQ-033 div with B=0 and HI/LO preloaded to 0xAA/0xBB -> with macro: HI/LO stay 0xAA/0xBB; without macro: HI=A, LO=0xFFFFFFFF.
REQ-034 Reset pulsed at busy cycle 3 of a div -> busy=0 and HI=LO=0 immediately; a subsequent mult completes normally.
